decode_exec_stage_reg: RTL and testbench
========================================

// Module: decode_exec_stage_reg
// PURPOSE
// - Parametrised decode->execute pipeline register; next generation of the fixed 64-bit ID/EX latch.
// - Adds valid/ready handshake, 2-entry skid buffer (registered in_ready), synchronous flush and bubble insertion.
// - Sits between decode (register-file read, immediate/shamt extraction) and execute (ALU).
// - Throughput 1 beat/cycle when downstream is ready; latency 1 cycle.
// PARAMETERS
// - DATA_W      16  width of Rs/Rd operand data
// - IMM_W       16  width of immediate value
// - SHAMT_W      5  width of shift amount
// - REG_ADDR_W   3  width of destination register index
// - CTRL_W       8  width of control-signal bundle; all-zero = NOP
// PORTS
// - clk        in   1           clock; all state updates on rising edge
// - rst_n      in   1           asynchronous active-low reset
// - flush      in   1           synchronous flush (branch/jump redirect)
// - in_valid   in   1           decode beat valid
// - in_ready   out  1           stage can accept a beat (registered)
// - imm_in     in   IMM_W       immediate from decode
// - shamt_in   in   SHAMT_W     shift amount from decode
// - rs_data_in in   DATA_W      Rs operand from register file
// - rd_data_in in   DATA_W      Rd operand from register file
// - rd_in      in   REG_ADDR_W  destination register index
// - ctrl_in    in   CTRL_W      control signals
// - out_valid  out  1           execute beat valid
// - out_ready  in   1           execute accepts beat
// - imm_ex, shamt_ex, rs_data_ex, rd_data_ex, rd_ex, ctrl_ex  out  (widths as inputs)  registered payload
// - stall_cnt  out  16          [STAGE_PERF_EN only] stall-cycle counter
// - bubble_cnt out  16          [STAGE_PERF_EN only] bubble-cycle counter
// BEHAVIOUR
// - Payload packed width PW = CTRL_W+REG_ADDR_W+2*DATA_W+SHAMT_W+IMM_W (64 at defaults); main and skid regs each PW.
// - accept = in_valid & in_ready; fire = out_valid & out_ready.
// - States (main_v, skid_v): EMPTY(0,0), ONE(1,0), TWO(1,1); out_valid = main_v; in_ready = ~skid_v.
// - EMPTY: accept -> ONE, main<=in. Otherwise stay.
// - ONE: accept&fire -> ONE, main<=in; accept&~fire -> TWO, skid<=in; ~accept&fire -> EMPTY; else hold.
// - TWO: in_ready=0; fire -> ONE, main<=skid; else hold (payload stable while out_valid & ~out_ready).
// - flush=1: next state EMPTY unconditionally; incoming beat in same cycle dropped; flush beats accept/fire.
// - Flush/empty payload regs keep old data, but ctrl_ex forced to 0 whenever out_valid=0 (NOP bubble).
// - Reset (async, rst_n=0): main_v=skid_v=0, all payload regs 0; so out_valid=0, in_ready=1, all *_ex=0.
// - Reset deasserted mid-stream: first accept is earliest on first rising edge with rst_n=1.
// - No combinational path in_valid->out_valid or out_ready->in_ready.
// - Beats exit in strict arrival order; no beat duplicated or lost except by flush.
// CONFIGURATION
// - STAGE_PERF_EN defined: stall_cnt +1 each cycle out_valid&~out_ready; bubble_cnt +1 each cycle ~out_valid.
//   Both saturate at 16'hFFFF, reset to 0 on rst_n, unaffected by flush.
// - STAGE_PERF_EN undefined: counters and ports absent; no extra logic.
// TESTING
// - Reset: rst_n=0 mid-traffic -> out_valid=0, in_ready=1, ctrl_ex=0 immediately (async).
// - Streaming: 8 beats imm=16'h0001..0008, out_ready=1 -> out at cycles 1..8, same order, in_ready stays 1.
// - Backpressure: out_ready=0 while sending A=16'hAAAA, B=16'hBBBB -> in_ready=0 after B; out holds A;
//   out_ready=1 -> A then B, in_ready=1 one cycle after A fires.
// - Flush in TWO with in_valid=1 (C=16'hCCCC) -> next cycle out_valid=0, ctrl_ex=0, C never emerges.
// - Simultaneous accept+fire in ONE: main=A, send B, out_ready=1 -> next cycle out=B, state ONE.
// - STAGE_PERF_EN: hold out_ready=0 with out_valid=1 for 70000 cycles -> stall_cnt=16'hFFFF, no wrap.

Source files
------------

// File: rtl/decode_exec_stage_reg.sv
// ---------------------------------------------------------------------------
// decode_exec_stage_reg
//   Decode->execute pipeline register with a valid/ready handshake. A
//   2-entry skid buffer lets in_ready come straight from a flop, so there is
//   no combinational path from out_ready to in_ready. The stage also supports
//   a synchronous flush and NOP bubble insertion. When downstream is ready it
//   moves 1 beat/cycle with 1 cycle of latency.
//
//   Optional feature macro: STAGE_PERF_EN (adds the stall/bubble counters)
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous flush; empties the stage and drops the
//                         beat offered in the same cycle
//   in_valid / in_ready   decode-side handshake (in_ready is registered)
//   imm_in .. ctrl_in     payload from decode
//   out_valid / out_ready execute-side handshake
//   imm_ex .. ctrl_ex     registered payload; ctrl_ex is 0 (NOP) when idle
//   stall_cnt, bubble_cnt saturating perf counters (STAGE_PERF_EN only)
// ---------------------------------------------------------------------------
module decode_exec_stage_reg #(
   parameter int DATA_W     = 16,
   parameter int IMM_W      = 16,
   parameter int SHAMT_W    = 5,
   parameter int REG_ADDR_W = 3,
   parameter int CTRL_W     = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IMM_W-1:0]      imm_in,
   input  logic [SHAMT_W-1:0]    shamt_in,
   input  logic [DATA_W-1:0]     rs_data_in,
   input  logic [DATA_W-1:0]     rd_data_in,
   input  logic [REG_ADDR_W-1:0] rd_in,
   input  logic [CTRL_W-1:0]     ctrl_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [IMM_W-1:0]      imm_ex,
   output logic [SHAMT_W-1:0]    shamt_ex,
   output logic [DATA_W-1:0]     rs_data_ex,
   output logic [DATA_W-1:0]     rd_data_ex,
   output logic [REG_ADDR_W-1:0] rd_ex,
   output logic [CTRL_W-1:0]     ctrl_ex
`ifdef STAGE_PERF_EN
   ,
   output logic [15:0]           stall_cnt,
   output logic [15:0]           bubble_cnt
`endif
);

   localparam int PW = CTRL_W + REG_ADDR_W + 2*DATA_W + SHAMT_W + IMM_W;

   // The encoding is {main_v, skid_v}. That way out_valid and in_ready are
   // single state bits, which keeps both outputs free of glue logic.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b10,
      TWO   = 2'b11
   } state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   main_q, skid_q;
   logic [PW-1:0]   in_pay;
   logic [CTRL_W-1:0] ctrl_raw;
   logic            accept, fire;
   logic            ld_main_in, ld_skid_in, ld_main_skid;

   assign in_pay    = {ctrl_in, rd_in, rs_data_in, rd_data_in, shamt_in, imm_in};
   assign out_valid = state_q[1];
   assign in_ready  = ~state_q[0];
   assign accept    = in_valid & in_ready;
   assign fire      = out_valid & out_ready;

   always_comb begin
      state_d      = state_q;
      ld_main_in   = 1'b0;
      ld_skid_in   = 1'b0;
      ld_main_skid = 1'b0;
      if (flush) begin
         // A flush overrides any accept or fire in the same cycle.
         // The payload regs keep stale data, which is harmless because
         // ctrl_ex is masked while the stage is empty.
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: if (accept) begin
               state_d    = ONE;
               ld_main_in = 1'b1;
            end
            ONE: begin
               if (accept && fire) begin
                  ld_main_in = 1'b1;
               end else if (accept) begin
                  state_d    = TWO;
                  ld_skid_in = 1'b1;
               end else if (fire) begin
                  state_d    = EMPTY;
               end
            end
            TWO: if (fire) begin
               // in_ready is low here, so no new beat can arrive alongside.
               state_d      = ONE;
               ld_main_skid = 1'b1;
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         if (ld_main_in)
            main_q <= in_pay;
         else if (ld_main_skid)
            main_q <= skid_q;
         if (ld_skid_in)
            skid_q <= in_pay;
      end
   end

   assign {ctrl_raw, rd_ex, rs_data_ex, rd_data_ex, shamt_ex, imm_ex} = main_q;
   // An idle stage presents a NOP to execute.
   assign ctrl_ex = out_valid ? ctrl_raw : '0;

`ifdef STAGE_PERF_EN
   // Flush does not affect either counter; only reset clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
         if (!out_valid && bubble_cnt != 16'hFFFF)
            bubble_cnt <= bubble_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_decode_exec_stage_reg.sv
module tb_decode_exec_stage_reg;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, out_ready;
   logic        in_ready, out_valid;
   logic [63:0] in_pay;
   logic [15:0] imm_in, rs_data_in, rd_data_in;
   logic [4:0]  shamt_in;
   logic [2:0]  rd_in;
   logic [7:0]  ctrl_in;
   logic [15:0] imm_ex, rs_data_ex, rd_data_ex;
   logic [4:0]  shamt_ex;
   logic [2:0]  rd_ex;
   logic [7:0]  ctrl_ex;
`ifdef STAGE_PERF_EN
   logic [15:0] stall_cnt, bubble_cnt;
`endif

   assign {ctrl_in, rd_in, rs_data_in, rd_data_in, shamt_in, imm_in} = in_pay;

   decode_exec_stage_reg dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .imm_in(imm_in), .shamt_in(shamt_in), .rs_data_in(rs_data_in),
      .rd_data_in(rd_data_in), .rd_in(rd_in), .ctrl_in(ctrl_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .imm_ex(imm_ex), .shamt_ex(shamt_ex), .rs_data_ex(rs_data_ex),
      .rd_data_ex(rd_data_ex), .rd_ex(rd_ex), .ctrl_ex(ctrl_ex)
`ifdef STAGE_PERF_EN
      , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: an ordered FIFO of at most two beats that are in flight.
   logic [63:0] q[$];
   int unsigned stall_m  = 0;
   int unsigned bubble_m = 0;

   function automatic logic [63:0] out_pay();
      return {ctrl_ex, rd_ex, rs_data_ex, rd_data_ex, shamt_ex, imm_ex};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // The task is entered between clock edges. It drives the inputs, checks
   // the outputs against the model, then advances one edge.
   task automatic cycle(input logic iv, input logic ordy, input logic fl, input logic [63:0] pay);
      logic acc, fir;
      in_valid  = iv;
      out_ready = ordy;
      flush     = fl;
      in_pay    = pay;
      check("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
      check("in_ready",  {63'd0, in_ready},  {63'd0, q.size() < 2});
      if (q.size() > 0) check("payload", out_pay(), q[0]);
      else              check("nop_ctrl", {56'd0, ctrl_ex}, 64'd0);
`ifdef STAGE_PERF_EN
      check("stall_cnt",  {48'd0, stall_cnt},  {48'd0, stall_m[15:0]});
      check("bubble_cnt", {48'd0, bubble_cnt}, {48'd0, bubble_m[15:0]});
`endif
      acc = iv && q.size() < 2;
      fir = ordy && q.size() > 0;
      if (q.size() > 0 && !ordy) begin if (stall_m < 16'hFFFF) stall_m++; end
      if (q.size() == 0)         begin if (bubble_m < 16'hFFFF) bubble_m++; end
      @(posedge clk);
      if (fl) q.delete();
      else begin
         if (fir) void'(q.pop_front());
         if (acc) q.push_back(pay);
      end
      @(negedge clk);
   endtask

   function automatic logic [63:0] rnd_pay();
      return {$urandom, $urandom};
   endfunction

   logic [63:0] pa, pb, pc;

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pay = '0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_in_ready",  {63'd0, in_ready},  64'd1);
      check("rst_payload",   out_pay(),          64'd0);
      rst_n = 1'b1;

      // Streaming: 8 beats, imm = 1..8, sink always ready
      for (int i = 1; i <= 8; i++)
         cycle(1'b1, 1'b1, 1'b0, {rnd_pay() & ~64'hFFFF} | 64'(i));
      cycle(1'b0, 1'b1, 1'b0, '0);
      cycle(1'b0, 1'b1, 1'b0, '0);

      // Backpressure: A and B with the sink stalled
      pa = {48'h12_3456_789A, 16'hAAAA};
      pb = {48'h00_1111_2222, 16'hBBBB};
      cycle(1'b1, 1'b0, 1'b0, pa);
      cycle(1'b1, 1'b0, 1'b0, pb);
      check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
      check("bp_holds_A", {48'd0, imm_ex}, 64'hAAAA);
      cycle(1'b1, 1'b0, 1'b0, rnd_pay());   // refused: skid is full
      cycle(1'b0, 1'b1, 1'b0, '0);          // A fires
      check("bp_B_next", {48'd0, imm_ex}, 64'hBBBB);
      check("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
      cycle(1'b0, 1'b1, 1'b0, '0);          // B fires

      // Flush while TWO, with C offered in the same cycle
      pc = {48'hFF_0000_0000, 16'hCCCC};
      cycle(1'b1, 1'b0, 1'b0, pa);
      cycle(1'b1, 1'b0, 1'b0, pb);
      cycle(1'b1, 1'b0, 1'b1, pc);
      check("flush_out_valid", {63'd0, out_valid}, 64'd0);
      check("flush_ctrl_nop", {56'd0, ctrl_ex}, 64'd0);
      repeat (3) cycle(1'b0, 1'b1, 1'b0, '0);

      // Simultaneous accept and fire in ONE
      cycle(1'b1, 1'b1, 1'b0, pa);
      cycle(1'b1, 1'b1, 1'b0, pb);
      check("accfire_B", {48'd0, imm_ex}, 64'hBBBB);
      cycle(1'b0, 1'b1, 1'b0, '0);

      // Random traffic with occasional flushes
      for (int i = 0; i < 2000; i++)
         cycle(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 55),
               1'($urandom_range(0, 99) < 4), rnd_pay());

      // Asynchronous reset in the middle of traffic
      cycle(1'b1, 1'b0, 1'b0, pa);
      cycle(1'b1, 1'b0, 1'b0, pb);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", {63'd0, out_valid}, 64'd0);
      check("arst_in_ready",  {63'd0, in_ready},  64'd1);
      check("arst_ctrl",      {56'd0, ctrl_ex},   64'd0);
      check("arst_payload",   out_pay(),          64'd0);
      q.delete();
      stall_m = 0; bubble_m = 0;
      in_valid = 1'b0;
      #1 rst_n = 1'b1;
      // First beat after reset release is accepted on the next edge
      cycle(1'b1, 1'b1, 1'b0, pc);
      for (int i = 0; i < 200; i++)
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, rnd_pay());
      repeat (3) cycle(1'b0, 1'b1, 1'b0, '0);

`ifdef STAGE_PERF_EN
      // Long stall: stall_cnt must saturate, not wrap
      cycle(1'b1, 1'b0, 1'b0, pa);
      out_ready = 1'b0; in_valid = 1'b0;
      repeat (70000) @(posedge clk);
      @(negedge clk);
      check("stall_sat", {48'd0, stall_cnt}, 64'hFFFF);
      check("stall_valid_held", {63'd0, out_valid}, 64'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
